// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and
// default chain/word geometry.
package ccff_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_WORD_W    = 8;

endpackage

// File: rtl/ccff_readback_packer.sv
// Serial-to-word packer for bits falling out of the config chain tail.
// Packs MSB-first; flush emits a partial word left-aligned with zero fill.
module ccff_readback_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cap,
  input  logic              tail_bit,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] nxt_acc;
  logic [CW-1:0]     nxt_cnt;
  logic [WORD_W-1:0] aligned;
  logic              emit;

  // acc keeps bits right-aligned; the shift moves a partial word up to the MSB
  always_comb begin
    nxt_acc = {acc[WORD_W-2:0], tail_bit};
    nxt_cnt = cnt + CW'(1);
    aligned = nxt_acc << (CW'(WORD_W) - nxt_cnt);
    emit    = cap && ((nxt_cnt == CW'(WORD_W)) || flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (emit) begin
        rb_data  <= aligned;
        rb_valid <= 1'b1;
        acc      <= '0;
        cnt      <= '0;
      end else if (cap) begin
        acc <= nxt_acc;
        cnt <= nxt_cnt;
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Transmit end of the configuration shift chain: serializes host words into
// ccff_head, reads back ccff_tail, and keeps fabric I/O isolated until loaded.
module ccff_bitstream_loader
  import ccff_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int WB_W = $clog2(WORD_W + 1);

  state_t            state;
  state_t            next_state;
  logic [WORD_W-1:0] sreg;
  logic [WB_W-1:0]   wbits;
  logic [CNT_W-1:0]  bit_cnt;

  assign bs_ready = (state == FETCH);
  assign busy     = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = FETCH; else next_state = IDLE;
      FETCH:  if (bs_valid) next_state = SHIFT; else next_state = FETCH;
      SHIFT: begin
        // chain length wins over word boundary, so leftover bits of the last word are dropped
        if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) next_state = FINISH;
        else if (wbits == WB_W'(1))           next_state = FETCH;
        else                                  next_state = SHIFT;
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state         <= IDLE;
      sreg          <= '0;
      wbits         <= '0;
      bit_cnt       <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      isol_n        <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          ccff_shift_en <= 1'b0;
          if (start) begin
            isol_n  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        FETCH: begin
          // gating the chain clock makes a host stall lossless
          ccff_shift_en <= 1'b0;
          if (bs_valid) begin
            sreg  <= bs_data;
            wbits <= WB_W'(WORD_W);
          end
        end
        SHIFT: begin
          ccff_head     <= sreg[WORD_W-1];
          ccff_shift_en <= 1'b1;
          sreg          <= {sreg[WORD_W-2:0], 1'b0};
          wbits         <= wbits - WB_W'(1);
          bit_cnt       <= bit_cnt + CNT_W'(1);
        end
        FINISH: begin
          ccff_shift_en <= 1'b0;
          done          <= 1'b1;
          isol_n        <= 1'b1;
        end
        default: ccff_shift_en <= 1'b0;
      endcase
    end
  end

  // the shift_en=1 cycle seen in FINISH carries the last chain bit, hence the flush
  ccff_readback_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk      (prog_clk),
    .rst      (prog_reset),
    .clear    ((state == IDLE) && start),
    .cap      (ccff_shift_en),
    .tail_bit (ccff_tail),
    .flush    (state == FINISH),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

endmodule
